keypad_sequencer: RTL
=====================

Name: keypad_sequencer

Overview:
- Upstream front end for `calculator`, which receives `key`, `startX`, `startY` and `startS` from this block and returns `done`.
- Takes the raw 4x4 keypad matrix code, debounces it and validates it.
- Classifies each press as a digit, an operator or clear, and sequences operand-X / operand-Y / operator loads into `calculator`.
- Holds off new entries until `calculator` reports `done`.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press, and again to accept its release.
- CNT_W, default 3: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_raw  input  8  raw matrix code; [7:4] row one-hot (bit7 = row0), [3:0] column one-hot (bit3 = col0); 0 = no key.
- done  input  1  from `calculator`; operation complete; a level or a pulse are both accepted.
- key  output  8  accepted key code, passed to `calculator`; held stable between accepted presses.
- startX  output  1  one-cycle pulse: load `key` as operand X.
- startY  output  1  one-cycle pulse: load `key` as operand Y.
- startS  output  1  one-cycle pulse: `key` is the operator; start the operation.
- err  output  1  one-cycle pulse: a valid press of the wrong class for the current state.
- state  output  2  FSM state, for debug: 0 WAIT_X, 1 WAIT_Y, 2 WAIT_S, 3 BUSY.

Behaviour:
- Reset: on rst=1 at a clock edge:
  - `key`=0, `startX`/`startY`/`startS`/`err`=0, `state`=WAIT_X.
  - Debounce counter=0; release-armed flag=1, i.e. the keypad is treated as released.
  - Reset mid-operation (any state, including BUSY) aborts without any pulse.
- Valid code: exactly one row bit and exactly one column bit set. Any other nonzero value is invalid; it resets the debounce counter and never produces an event or `err`.
- Debounce:
  - While armed, `key_raw` must hold the same valid code for DEBOUNCE_CYCLES consecutive cycles. On the cycle the count completes, a press event fires for that code and armed clears.
  - A change of code restarts the count.
  - Re-arm requires `key_raw`=0 for DEBOUNCE_CYCLES consecutive cycles.
  - Exactly one event per physical press, no auto-repeat.
- Classification, by row r and column c:
  - Digit: r0-2 with c0-2 (digits 1..9 row-major); r3c1 = digit 0.
  - Operator: c3 in any row (r0 `+`, r1 `-`, r2 `*`, r3 `/`).
  - Clear: r3c0 (8'b0001_1000).
  - Reserved: r3c2; ignored.
- Timing: a press event is registered one cycle later. `key` updates and the strobe pulses on that same edge, so `key` is valid the whole cycle the strobe is high and stays unchanged until the next accepted (strobed) press.
- FSM transitions:
  - WAIT_X: digit -> `key`<=code, `startX`, go to WAIT_Y. Operator -> `err`, stay.
  - WAIT_Y: digit -> `key`<=code, `startY`, go to WAIT_S. Operator -> `err`, stay.
  - WAIT_S: operator -> `key`<=code, `startS`, go to BUSY. Digit -> `err`, stay.
  - BUSY: `done`=1 -> WAIT_X. Digit and operator presses are consumed and dropped (no `err`, no queueing).
- Clear in any state: go to WAIT_X, `key`<=0, no strobe, no `err`.
- Simultaneous events: clear and `done` in the same cycle -> WAIT_X (same result either way). In non-BUSY states `done` is ignored.
- At most one of `startX`/`startY`/`startS`/`err` is high in any cycle.
- The debounce counter saturates and does not wrap while the input stays stable.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then `key_raw`=8'h84 held 6 cycles -> exactly one `startX` pulse on the 5th edge after the value is applied, `key`=8'h84, `state`=1.
- Release 4 cycles, 8'h44 held 4 cycles -> `startY`, `key`=8'h44. Release, then 8'h81 -> `startS`, `key`=8'h81, `state`=3. Pulse `done` -> `state`=0.
- Bounce: 8'h84 for 2 cycles, 0 for 1, 8'h84 for 2 -> no event. Pressing 8'h84 twice without a 4-cycle release -> only one `startX`.
- 8'h81 (operator) in WAIT_X -> one `err` pulse, `state` stays 0, `key` stays 0. 8'hC4 (two rows set) -> no event, no `err`.
- In BUSY, press 8'h84 -> no strobe, no `err`. Then clear 8'h18 -> `state`=0, `key`=0. Clear asserted in the same cycle as `done` -> `state`=0.
- Assert `rst` while in WAIT_S with a press counting -> all outputs 0 next edge, `state`=0, the in-progress press is not accepted.

Source files
------------

// File: rtl/keypad_sequencer.sv
// Keypad front end for the calculator: debounces and validates the raw 4x4 matrix code,
// classifies each press and sequences operand-X / operand-Y / operator loads.
module keypad_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_raw,
    input  logic       done,
    output logic [7:0] key,
    output logic       startX,
    output logic       startY,
    output logic       startS,
    output logic       err,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [7:0] CODE_CLEAR    = 8'h18;
    localparam logic [7:0] CODE_RESERVED = 8'h12;

    typedef enum logic [1:0] {
        WAIT_X = 2'd0,
        WAIT_Y = 2'd1,
        WAIT_S = 2'd2,
        BUSY   = 2'd3
    } state_t;

    // Debounce front end
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       last_reg;
    logic             armed_reg;
    logic             evt_reg;
    logic [7:0]       evt_code_reg;
    logic             code_valid, code_zero, code_stable;
    logic             press_fire, rearm;

    always_comb begin
        code_zero   = (key_raw == 8'h00);
        code_valid  = $onehot(key_raw[7:4]) && $onehot(key_raw[3:0]);
        code_stable = (key_raw == last_reg);
        cnt_next    = '0;
        // Invalid codes leave the counter at zero; valid or idle inputs count up and saturate.
        if (code_valid || code_zero) begin
            if (!code_stable)
                cnt_next = CNT_W'(1);
            else if (cnt_reg == CNT_DONE)
                cnt_next = cnt_reg;
            else
                cnt_next = cnt_reg + 1'b1;
        end
        press_fire = armed_reg && code_valid && (cnt_next == CNT_DONE);
        rearm      = !armed_reg && code_zero && (cnt_next == CNT_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            last_reg     <= 8'h00;
            armed_reg    <= 1'b1;
            evt_reg      <= 1'b0;
            evt_code_reg <= 8'h00;
        end else begin
            cnt_reg  <= cnt_next;
            last_reg <= key_raw;
            evt_reg  <= press_fire;
            if (press_fire) begin
                evt_code_reg <= key_raw;
                armed_reg    <= 1'b0;
            end else if (rearm) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // Classification of the accepted code; column 3 is bit 0 of the column field.
    logic is_op, is_clear, is_digit;

    always_comb begin
        is_op    = evt_code_reg[0];
        is_clear = (evt_code_reg == CODE_CLEAR);
        is_digit = !is_op && !is_clear && (evt_code_reg != CODE_RESERVED);
    end

    // Sequencer FSM
    state_t     state_reg, state_next;
    logic [7:0] key_reg, key_next;
    logic       start_x_reg, start_x_next;
    logic       start_y_reg, start_y_next;
    logic       start_s_reg, start_s_next;
    logic       err_reg, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= WAIT_X;
            key_reg     <= 8'h00;
            start_x_reg <= 1'b0;
            start_y_reg <= 1'b0;
            start_s_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            key_reg     <= key_next;
            start_x_reg <= start_x_next;
            start_y_reg <= start_y_next;
            start_s_reg <= start_s_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (evt_reg && is_clear) begin
            state_next = WAIT_X;
        end else begin
            case (state_reg)
                WAIT_X:  if (evt_reg && is_digit) state_next = WAIT_Y;
                WAIT_Y:  if (evt_reg && is_digit) state_next = WAIT_S;
                WAIT_S:  if (evt_reg && is_op)    state_next = BUSY;
                BUSY:    if (done)                state_next = WAIT_X;
                default: state_next = WAIT_X;
            endcase
        end
    end

    always_comb begin
        key_next     = key_reg;
        start_x_next = 1'b0;
        start_y_next = 1'b0;
        start_s_next = 1'b0;
        err_next     = 1'b0;
        if (evt_reg) begin
            if (is_clear) begin
                key_next = 8'h00;
            end else begin
                // Presses during BUSY are swallowed silently.
                case (state_reg)
                    WAIT_X: begin
                        if (is_digit) begin
                            key_next     = evt_code_reg;
                            start_x_next = 1'b1;
                        end else if (is_op) begin
                            err_next = 1'b1;
                        end
                    end
                    WAIT_Y: begin
                        if (is_digit) begin
                            key_next     = evt_code_reg;
                            start_y_next = 1'b1;
                        end else if (is_op) begin
                            err_next = 1'b1;
                        end
                    end
                    WAIT_S: begin
                        if (is_op) begin
                            key_next     = evt_code_reg;
                            start_s_next = 1'b1;
                        end else if (is_digit) begin
                            err_next = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign key    = key_reg;
    assign startX = start_x_reg;
    assign startY = start_y_reg;
    assign startS = start_s_reg;
    assign err    = err_reg;
    assign state  = state_reg;

endmodule
